// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and the round-robin pick function for the edge event arbiter.
// rr_pick is written so that a testbench model can call it directly.
package edge_evt_pkg;

   typedef enum logic [0:0] {DET_RISE, DET_PULSE} detect_mode_t;

   localparam int MAX_N = 32;

   // Returns the first set index in pending, searching ptr, ptr+1, ... modulo n; 0 if none.
   // The descending loop lets the highest-priority hit overwrite the lower-priority ones.
   function automatic int rr_pick(input logic [MAX_N-1:0] pending, input int ptr, input int n);
      int idx;
      rr_pick = 0;
      for (int k = MAX_N - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (pending[idx[4:0]]) rr_pick = idx;
         end
      end
   endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event handshake carrying the channel index of the presented event.
interface edge_event_arbiter_if #(parameter int ID_W = 2);

   logic            out_valid;
   logic            out_ready;
   logic [ID_W-1:0] out_id;

   modport master (output out_valid, output out_id, input out_ready);
   modport slave  (input out_valid, input out_id, output out_ready);

endinterface

// File: rtl/edge_event_arbiter_channel.sv
// One input channel: two-deep history, edge/pulse detection, pending latch, sticky overflow.
module edge_event_channel
   import edge_evt_pkg::*;
#(
   parameter detect_mode_t MODE = DET_RISE
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic consume,
   output logic pending,
   output logic overflow,
   input  logic clr_overflow
);

   logic a_r;
   logic a_r2;
   logic det;

   always_comb begin
      if (MODE == DET_RISE) det = a & ~a_r;
      else                  det = ~a & a_r & ~a_r2;
   end

   // A detection coinciding with the consume of the previous event re-arms pending without overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r      <= 1'b0;
         a_r2     <= 1'b0;
         pending  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         a_r      <= a;
         a_r2     <= a_r;
         pending  <= det | (pending & ~consume);
         overflow <= (overflow & ~clr_overflow) | (det & pending & ~consume);
      end
   end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge/pulse event front end serialised through a round-robin arbiter.
module edge_event_arbiter
   import edge_evt_pkg::*;
#(
   parameter int           N    = 4,
   parameter detect_mode_t MODE = DET_RISE,
   localparam int          ID_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         a,
   edge_event_arbiter_if.master evt,
   output logic [N-1:0]         overflow,
   input  logic                 clr_overflow
);

   logic [N-1:0]    pending;
   logic [N-1:0]    consume;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] pick;
   logic            xfer;

   for (genvar i = 0; i < N; i++) begin : g_ch
      assign consume[i] = xfer & (pick == ID_W'(i));

      edge_event_channel #(.MODE(MODE)) u_ch (
         .clk          (clk),
         .rst          (rst),
         .a            (a[i]),
         .consume      (consume[i]),
         .pending      (pending[i]),
         .overflow     (overflow[i]),
         .clr_overflow (clr_overflow)
      );
   end

   always_comb begin
      pick = ID_W'(rr_pick(MAX_N'(pending), int'(rr_ptr), N));
   end

   assign evt.out_valid = |pending;
   assign evt.out_id    = pick;
   assign xfer          = evt.out_valid & evt.out_ready;

   // Pointer moves to the slot after the winner only on a completed transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (pick == ID_W'(N - 1)) ? '0 : pick + ID_W'(1);
      end
   end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench: one rising-edge and one pulse-mode instance share stimulus, each test starts from reset.
module tb_edge_event_arbiter;
   import edge_evt_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] a = 4'b0000;
   logic       ready = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] ovf_r;
   logic [3:0] ovf_p;
   int         pass_cnt = 0;
   int         total = 0;

   edge_event_arbiter_if #(.ID_W(2)) ifr ();
   edge_event_arbiter_if #(.ID_W(2)) ifp ();

   assign ifr.out_ready = ready;
   assign ifp.out_ready = ready;

   edge_event_arbiter #(.N(4), .MODE(DET_RISE)) dut_rise (
      .clk(clk), .rst(rst), .a(a), .evt(ifr), .overflow(ovf_r), .clr_overflow(clr)
   );

   edge_event_arbiter #(.N(4), .MODE(DET_PULSE)) dut_pulse (
      .clk(clk), .rst(rst), .a(a), .evt(ifp), .overflow(ovf_p), .clr_overflow(clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; a = 4'b0000; ready = 1'b0; clr = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (ifr.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifr.out_valid);
      else pass_cnt++;
      total++;
      if (ifr.out_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", ifr.out_id);
      else pass_cnt++;
      total++;
      if (ovf_r !== 4'b0000 || ovf_p !== 4'b0000) $display("FAIL reset_ovf: got %b/%b want 0000", ovf_r, ovf_p);
      else pass_cnt++;
      total++;
      if (ifp.out_valid !== 1'b0) $display("FAIL reset_valid_pulse: got %b want 0", ifp.out_valid);
      else pass_cnt++;
   endtask

   task automatic test_rise_single();
      do_reset();
      ready = 1'b1;
      a = 4'b0100;
      tick();
      total++;
      if (ifr.out_valid !== 1'b1 || ifr.out_id !== 2'd2)
         $display("FAIL rise_event: got v=%b id=%0d want v=1 id=2", ifr.out_valid, ifr.out_id);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (ifr.out_valid !== 1'b0) $display("FAIL rise_norepeat%0d: got v=%b want 0", i, ifr.out_valid);
         else pass_cnt++;
      end
   endtask

   task automatic test_pulse_filter();
      int events;
      do_reset();
      ready = 1'b1;
      a = 4'b0010; tick();
      a = 4'b0000; tick();
      total++;
      if (ifp.out_valid !== 1'b1 || ifp.out_id !== 2'd1)
         $display("FAIL pulse_one: got v=%b id=%0d want v=1 id=1", ifp.out_valid, ifp.out_id);
      else pass_cnt++;
      tick();
      total++;
      if (ifp.out_valid !== 1'b0) $display("FAIL pulse_one_clear: got v=%b want 0", ifp.out_valid);
      else pass_cnt++;
      // two-cycle high must be rejected
      events = 0;
      a = 4'b0010; tick(); events += int'(ifp.out_valid);
      tick();              events += int'(ifp.out_valid);
      a = 4'b0000; tick(); events += int'(ifp.out_valid);
      tick();              events += int'(ifp.out_valid);
      total++;
      if (events != 0) $display("FAIL pulse_wide: got %0d events want 0", events);
      else pass_cnt++;
      // 0-1-0-1-0 on channel 0
      events = 0;
      a = 4'b0001; tick(); events += int'(ifp.out_valid);
      a = 4'b0000; tick(); events += int'(ifp.out_valid);
      a = 4'b0001; tick(); events += int'(ifp.out_valid);
      a = 4'b0000; tick(); events += int'(ifp.out_valid);
      total++;
      if (ifp.out_valid !== 1'b1 || ifp.out_id !== 2'd0)
         $display("FAIL pulse_second: got v=%b id=%0d want v=1 id=0", ifp.out_valid, ifp.out_id);
      else pass_cnt++;
      tick(); events += int'(ifp.out_valid);
      tick(); events += int'(ifp.out_valid);
      total++;
      if (events != 2) $display("FAIL pulse_double: got %0d events want 2", events);
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp0 [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      logic [1:0] exp2 [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      ready = 1'b1;
      a = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (ifr.out_valid !== 1'b1 || ifr.out_id !== exp0[i])
            $display("FAIL rr0_step%0d: got v=%b id=%0d want v=1 id=%0d", i, ifr.out_valid, ifr.out_id, exp0[i]);
         else pass_cnt++;
      end
      tick();
      total++;
      if (ifr.out_valid !== 1'b0) $display("FAIL rr0_drain: got v=%b want 0", ifr.out_valid);
      else pass_cnt++;
      // move the pointer to 2 via a single transfer on channel 1
      a = 4'b0000; tick();
      a = 4'b0010; tick();
      total++;
      if (ifr.out_id !== 2'd1) $display("FAIL rr_setup: got id=%0d want 1", ifr.out_id);
      else pass_cnt++;
      tick();
      a = 4'b0000; tick();
      a = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (ifr.out_valid !== 1'b1 || ifr.out_id !== exp2[i])
            $display("FAIL rr2_step%0d: got v=%b id=%0d want v=1 id=%0d", i, ifr.out_valid, ifr.out_id, exp2[i]);
         else pass_cnt++;
      end
      tick();
      total++;
      if (ifr.out_valid !== 1'b0) $display("FAIL rr2_drain: got v=%b want 0", ifr.out_valid);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      do_reset();
      a = 4'b1000; tick();
      a = 4'b0000; tick();
      a = 4'b1000; tick();
      total++;
      if (ifr.out_valid !== 1'b1 || ifr.out_id !== 2'd3 || ovf_r !== 4'b1000)
         $display("FAIL bp_held: got v=%b id=%0d ovf=%b want v=1 id=3 ovf=1000", ifr.out_valid, ifr.out_id, ovf_r);
      else pass_cnt++;
      ready = 1'b1; tick();
      total++;
      if (ifr.out_valid !== 1'b0) $display("FAIL bp_single: got v=%b want 0", ifr.out_valid);
      else pass_cnt++;
      total++;
      if (ovf_r !== 4'b1000) $display("FAIL bp_sticky: got %b want 1000", ovf_r);
      else pass_cnt++;
      clr = 1'b1; tick(); clr = 1'b0;
      total++;
      if (ovf_r !== 4'b0000) $display("FAIL bp_clear: got %b want 0000", ovf_r);
      else pass_cnt++;
      // a fresh overflow in the clearing cycle survives the clear
      ready = 1'b0;
      a = 4'b0000; tick();
      a = 4'b1000; tick();
      a = 4'b0000; tick();
      a = 4'b1000; clr = 1'b1; tick(); clr = 1'b0;
      total++;
      if (ovf_r !== 4'b1000) $display("FAIL bp_clr_race: got %b want 1000", ovf_r);
      else pass_cnt++;
   endtask

   task automatic test_consume_redetect();
      do_reset();
      a = 4'b0001; tick();
      a = 4'b0000; tick();
      ready = 1'b1;
      a = 4'b0001; tick();
      total++;
      if (ifr.out_valid !== 1'b1 || ifr.out_id !== 2'd0 || ovf_r !== 4'b0000)
         $display("FAIL redetect: got v=%b id=%0d ovf=%b want v=1 id=0 ovf=0000", ifr.out_valid, ifr.out_id, ovf_r);
      else pass_cnt++;
      tick();
      total++;
      if (ifr.out_valid !== 1'b0) $display("FAIL redetect_drain: got v=%b want 0", ifr.out_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      a = 4'b1010; tick();
      a = 4'b0000; tick();
      a = 4'b0010; tick();
      total++;
      if (ifr.out_valid !== 1'b1 || ifr.out_id !== 2'd1 || ovf_r !== 4'b0010)
         $display("FAIL mid_setup: got v=%b id=%0d ovf=%b want v=1 id=1 ovf=0010", ifr.out_valid, ifr.out_id, ovf_r);
      else pass_cnt++;
      rst = 1'b1; ready = 1'b1; tick(); rst = 1'b0;
      total++;
      if (ifr.out_valid !== 1'b0 || ifr.out_id !== 2'd0 || ovf_r !== 4'b0000)
         $display("FAIL mid_reset: got v=%b id=%0d ovf=%b want v=0 id=0 ovf=0000", ifr.out_valid, ifr.out_id, ovf_r);
      else pass_cnt++;
      tick();
      total++;
      if (ifr.out_valid !== 1'b1 || ifr.out_id !== 2'd1)
         $display("FAIL mid_held_high: got v=%b id=%0d want v=1 id=1", ifr.out_valid, ifr.out_id);
      else pass_cnt++;
      tick();
      total++;
      if (ifr.out_valid !== 1'b0) $display("FAIL mid_drain: got v=%b want 0", ifr.out_valid);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_rise_single();
      test_pulse_filter();
      test_round_robin();
      test_backpressure();
      test_consume_redetect();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel event front end: samples N single-bit inputs and detects either rising edges or isolated one-cycle pulses on each.
- Latches each detected event as pending, then serialises the pending events to one consumer through a round-robin arbiter and a valid/ready handshake.
- Sits between raw status/strobe lines and an interrupt- or command-style consumer that can accept one event per cycle.

Parameters:
- N, 4: number of input channels; N >= 2.
- MODE, DET_RISE: detection mode for all channels, type detect_mode_t; DET_RISE = 0->1 transition, DET_PULSE = 0-1-0 with exactly one high cycle.
- ID_W, $clog2(N): width of out_id; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- a  in  N  raw event inputs, already synchronous to clk.
- out_valid  out  1  at least one event pending.
- out_ready  in  1  consumer accepts the presented event.
- out_id  out  ID_W  channel index of the presented event.
- overflow  out  N  sticky per-channel flag: an event was lost.
- clr_overflow  in  1  clears all overflow bits.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - Clears all history registers, pending bits and overflow bits.
  - Sets the round-robin pointer rr_ptr to 0.
  - Outputs after reset: out_valid=0, out_id=0, overflow=0.
- Detection, per channel i, using registered history a_r (1 cycle) and a_r2 (2 cycles):
  - DET_RISE: det[i] = a[i] & ~a_r[i].
  - DET_PULSE: det[i] = ~a[i] & a_r[i] & ~a_r2[i], asserted in the cycle a[i] returns low.
  - Because history resets to 0, an input high at reset release counts as a rising edge (DET_RISE).
  - A pulse in DET_PULSE mode is detected only if a_r2 saw 0 after reset.
- Pending:
  - pending[i] sets at the posedge where det[i]=1.
  - Latency from the detection cycle to out_valid is 1 cycle (registered), with no combinational path from a to out_valid.
- Arbitration:
  - out_valid = |pending.
  - out_id = first i with pending[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo N.
  - out_id = 0 when out_valid=0.
  - out_id is stable while out_valid=1 and out_ready=0, unless a higher-priority channel becomes pending; re-arbitration each cycle is allowed, and the consumer must sample only on transfer.
- Transfer (out_valid & out_ready at posedge):
  - Clears pending[out_id].
  - Sets rr_ptr <= (out_id+1) mod N, wrapping N-1 -> 0.
  - rr_ptr is unchanged when there is no transfer.
- Simultaneous events and boundaries:
  - det[i] in the same cycle that pending[i] is consumed: pending[i] stays 1; the new event is kept and there is no overflow.
  - det[i] while pending[i]=1 and not consumed that cycle: the event is merged, pending stays 1, and overflow[i] is set.
  - clr_overflow=1 clears all overflow bits at the posedge; a new overflow in the same cycle wins, so that bit reads 1.
  - out_ready=1 with out_valid=0: no effect.
  - Events on multiple channels in one cycle: all pending bits set together, then drained one per cycle in round-robin order.
  - rst asserted mid-operation: all pending events are discarded and there is no transfer that cycle.

Decomposition:
- Package edge_evt_pkg:
  - typedef enum logic [0:0] detect_mode_t {DET_RISE, DET_PULSE}.
  - Function rr_pick(pending, ptr) returning the index; usable by the bench model.
- Sub-module edge_event_channel, one per channel via generate:
  - Contains history registers, detection, pending and overflow logic.
  - Ports: clk, rst, a, consume, pending, overflow, clr_overflow.
- Top level holds rr_ptr, the arbiter and the handshake.

Test Plan (N=4):
- Rise, single channel: DET_RISE, a=0000 -> 0100 held, out_ready=1 -> out_valid=1 with out_id=2 exactly 1 cycle after a rises, for exactly 1 cycle; no repeat while a stays high.
- Pulse filtering: DET_PULSE, a[1] high 1 cycle -> one event, out_id=1. a[1] high 2 cycles -> no event. a[0] 0-1-0-1-0 -> two events.
- Round-robin fairness: DET_RISE, a 0000 -> 1111 in one cycle, out_ready=1 -> out_id sequence 0,1,2,3, then out_valid=0. Repeat with rr_ptr=2 -> sequence 2,3,0,1.
- Backpressure and overflow: out_ready=0, two rising edges on a[3] (0-1-0-1) -> pending held, overflow=1000. Then out_ready=1 -> a single event with out_id=3. clr_overflow=1 -> overflow=0000.
- Consume-and-redetect: pending[0]=1, edge on a[0] in the cycle of the transfer of id 0 -> out_valid stays 1 next cycle with out_id=0, overflow[0]=0.
- Reset mid-operation: pending=1010, overflow=0010, rst=1 for 1 cycle -> out_valid=0, out_id=0, overflow=0000. a held high across reset (DET_RISE) -> event reported after release.
